// File: rtl/bp_update_ctrl.sv
// Write sequencer for the branch predictor PHT/BTB: post-reset table sweep, then
// arbitration of the single write port between fetch lookups and a queue of resolved-branch updates.
module bp_update_ctrl #(
  parameter int         PHT_IDX_W  = 10,
  parameter int         BTB_IDX_W  = 7,
  parameter int         BTB_TAG_W  = 22,
  parameter int         DEPTH      = 4,
  parameter int         STARVE_MAX = 3,
  parameter logic [1:0] PHT_INIT   = 2'b01
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                upd_valid_i,
  output logic                                upd_ready_o,
  input  logic [1+PHT_IDX_W+2-1:0]            pht_wbus_i,
  input  logic [2+BTB_IDX_W+BTB_TAG_W+32-1:0] btb_wbus_i,
  input  logic                                lookup_req_i,
  output logic                                lookup_gnt_o,
  output logic                                pht_we_o,
  output logic [PHT_IDX_W-1:0]                pht_waddr_o,
  output logic [1:0]                          pht_wdata_o,
  output logic                                btb_we_o,
  output logic [BTB_IDX_W-1:0]                btb_waddr_o,
  output logic                                btb_wvalid_o,
  output logic [BTB_TAG_W-1:0]                btb_wtag_o,
  output logic [31:0]                         btb_wtarget_o,
  output logic                                init_done_o,
  output logic [$clog2(DEPTH):0]              q_count_o
);

  localparam int PHT_W = 1 + PHT_IDX_W + 2;
  localparam int BTB_W = 2 + BTB_IDX_W + BTB_TAG_W + 32;
  localparam int ENT_W = PHT_W + BTB_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state_reg, state_next;
  logic [PHT_IDX_W-1:0] idx_reg, idx_next;
  logic [ENT_W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [STV_W-1:0]     starve_reg, starve_next;

  logic             push, wslot;
  logic [ENT_W-1:0] head;
  logic [PHT_W-1:0] head_pht;
  logic [BTB_W-1:0] head_btb;

  assign head     = mem_reg[rd_ptr_reg];
  assign head_pht = head[ENT_W-1 -: PHT_W];
  assign head_btb = head[BTB_W-1:0];
  assign q_count_o = count_reg;

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    count_next    = count_reg;
    starve_next   = starve_reg;
    push          = 1'b0;
    wslot         = 1'b0;
    upd_ready_o   = 1'b0;
    lookup_gnt_o  = 1'b0;
    init_done_o   = 1'b0;
    pht_we_o      = 1'b0;
    pht_waddr_o   = '0;
    pht_wdata_o   = '0;
    btb_we_o      = 1'b0;
    btb_waddr_o   = '0;
    btb_wvalid_o  = 1'b0;
    btb_wtag_o    = '0;
    btb_wtarget_o = '0;
    case (state_reg)
      ST_INIT: begin
        pht_we_o    = 1'b1;
        pht_waddr_o = idx_reg;
        pht_wdata_o = PHT_INIT;
        // BTB is shallower: only the low part of the sweep touches it
        btb_we_o    = ((idx_reg >> BTB_IDX_W) == '0);
        btb_waddr_o = idx_reg[BTB_IDX_W-1:0];
        idx_next    = idx_reg + 1'b1;
        if (&idx_reg) state_next = ST_RUN;
      end
      default: begin
        init_done_o  = 1'b1;
        upd_ready_o  = (count_reg < CNT_W'(DEPTH));
        push         = upd_valid_i & upd_ready_o
                       & (pht_wbus_i[PHT_W-1] | btb_wbus_i[BTB_W-1]);
        wslot        = (count_reg != '0)
                       & (!lookup_req_i | (starve_reg == STV_W'(STARVE_MAX)));
        lookup_gnt_o = lookup_req_i & !wslot;

        pht_we_o      = wslot & head_pht[PHT_W-1];
        pht_waddr_o   = head_pht[PHT_IDX_W+1:2];
        pht_wdata_o   = head_pht[1:0];
        btb_we_o      = wslot & head_btb[BTB_W-1];
        btb_wvalid_o  = head_btb[BTB_W-2];
        btb_waddr_o   = head_btb[BTB_TAG_W+32 +: BTB_IDX_W];
        btb_wtag_o    = head_btb[32 +: BTB_TAG_W];
        btb_wtarget_o = head_btb[31:0];

        case ({push, wslot})
          2'b10:   count_next = count_reg + 1'b1;
          2'b01:   count_next = count_reg - 1'b1;
          default: count_next = count_reg;
        endcase

        if (count_reg == '0 || wslot)
          starve_next = '0;
        else if (lookup_gnt_o && starve_reg != STV_W'(STARVE_MAX))
          starve_next = starve_reg + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_INIT;
      idx_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      count_reg  <= count_next;
      starve_reg <= starve_next;
      if (push)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (wslot) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= {pht_wbus_i, btb_wbus_i};
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Randomized bench for bp_update_ctrl against a queue-based reference of the
// sweep, the update FIFO and the lookup/update arbitration rules.
module tb_bp_update_ctrl;

  localparam int INIT_CYCLES = 1024;
  localparam int BTB_DEPTH   = 128;
  localparam int QDEPTH      = 4;
  localparam int SMAX        = 3;

  typedef struct {
    logic [12:0] pht;
    logic [62:0] btb;
  } upd_t;

  logic        clk = 1'b0;
  logic        srst;
  logic        upd_valid;
  logic        upd_ready;
  logic [12:0] pht_wbus;
  logic [62:0] btb_wbus;
  logic        lookup_req;
  logic        lookup_gnt;
  logic        pht_we;
  logic [9:0]  pht_waddr;
  logic [1:0]  pht_wdata;
  logic        btb_we;
  logic [6:0]  btb_waddr;
  logic        btb_wvalid;
  logic [21:0] btb_wtag;
  logic [31:0] btb_wtarget;
  logic        init_done;
  logic [2:0]  q_count;

  int   checks = 0;
  int   failures = 0;
  upd_t model_q[$];
  int   init_cnt = 0;
  int   starve = 0;
  bit   model_valid = 0;

  always #5 clk = ~clk;

  bp_update_ctrl dut (
    .clk          (clk),
    .reset        (srst),
    .upd_valid_i  (upd_valid),
    .upd_ready_o  (upd_ready),
    .pht_wbus_i   (pht_wbus),
    .btb_wbus_i   (btb_wbus),
    .lookup_req_i (lookup_req),
    .lookup_gnt_o (lookup_gnt),
    .pht_we_o     (pht_we),
    .pht_waddr_o  (pht_waddr),
    .pht_wdata_o  (pht_wdata),
    .btb_we_o     (btb_we),
    .btb_waddr_o  (btb_waddr),
    .btb_wvalid_o (btb_wvalid),
    .btb_wtag_o   (btb_wtag),
    .btb_wtarget_o(btb_wtarget),
    .init_done_o  (init_done),
    .q_count_o    (q_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle init_cnt=%0d q=%0d)", tag, got, exp, init_cnt, model_q.size());
    end
  endtask

  // Inputs are already set; check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit   run_ph, exp_ready, wslot, gnt, accept;
    upd_t head;
    #1;
    run_ph    = (init_cnt >= INIT_CYCLES);
    exp_ready = run_ph && (model_q.size() < QDEPTH);
    wslot     = run_ph && (model_q.size() > 0) && (!lookup_req || starve == SMAX);
    gnt       = run_ph && lookup_req && !wslot;
    accept    = upd_valid && exp_ready && (pht_wbus[12] || btb_wbus[62]);
    if (wslot) head = model_q[0];
    if (model_valid) begin
      check("init_done", 64'(init_done), 64'(run_ph));
      check("upd_ready", 64'(upd_ready), 64'(exp_ready));
      check("lookup_gnt", 64'(lookup_gnt), 64'(gnt));
      check("q_count", 64'(q_count), 64'(model_q.size()));
      if (!run_ph) begin
        check("init_pht_we", 64'(pht_we), 64'd1);
        check("init_pht_addr", 64'(pht_waddr), 64'(init_cnt));
        check("init_pht_data", 64'(pht_wdata), 64'd1);
        check("init_btb_we", 64'(btb_we), 64'(init_cnt < BTB_DEPTH));
        if (init_cnt < BTB_DEPTH) begin
          check("init_btb_addr", 64'(btb_waddr), 64'(init_cnt));
          check("init_btb_fields", {btb_wvalid, btb_wtag, btb_wtarget}, 64'd0);
        end
      end else begin
        check("pht_we", 64'(pht_we), 64'(wslot && head.pht[12]));
        check("btb_we", 64'(btb_we), 64'(wslot && head.btb[62]));
        if (wslot) begin
          $display("write pht_we=%0d idx=%h st=%0d btb_we=%0d v=%0d idx=%h tag=%h tgt=%h",
                   head.pht[12], head.pht[11:2], head.pht[1:0], head.btb[62], head.btb[61],
                   head.btb[60:54], head.btb[53:32], head.btb[31:0]);
          if (head.pht[12]) begin
            check("pht_addr", 64'(pht_waddr), 64'(head.pht[11:2]));
            check("pht_data", 64'(pht_wdata), 64'(head.pht[1:0]));
          end
          if (head.btb[62]) begin
            check("btb_addr", 64'(btb_waddr), 64'(head.btb[60:54]));
            check("btb_wvalid", 64'(btb_wvalid), 64'(head.btb[61]));
            check("btb_tag", 64'(btb_wtag), 64'(head.btb[53:32]));
            check("btb_target", 64'(btb_wtarget), 64'(head.btb[31:0]));
          end
        end
      end
    end
    @(posedge clk);
    if (srst) begin
      model_q.delete();
      starve      = 0;
      init_cnt    = 0;
      model_valid = 1;
    end else if (!run_ph) begin
      init_cnt++;
    end else begin
      if (model_q.size() == 0 || wslot) starve = 0;
      else if (gnt && starve < SMAX) starve++;
      if (wslot) void'(model_q.pop_front());
      if (accept) model_q.push_back('{pht: pht_wbus, btb: btb_wbus});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    upd_valid  = 1'b0;
    lookup_req = 1'b0;
    pht_wbus   = '0;
    btb_wbus   = '0;
  endtask

  task automatic rand_inputs(input int req_pct, input int vld_pct, input int we_pct);
    lookup_req = ($urandom_range(99) < req_pct);
    upd_valid  = ($urandom_range(99) < vld_pct);
    pht_wbus   = 13'($urandom);
    btb_wbus   = {31'($urandom), $urandom};
    pht_wbus[12] = ($urandom_range(99) < we_pct);
    btb_wbus[62] = ($urandom_range(99) < we_pct);
  endtask

  initial begin
    srst = 1'b1;
    idle();
    @(negedge clk);
    step();
    step();
    srst = 1'b0;

    // Full sweep, idle inputs
    for (int i = 0; i < INIT_CYCLES; i++) step();

    // Single update with no lookup pressure
    upd_valid = 1'b1;
    pht_wbus  = {1'b1, 10'h05A, 2'b10};
    btb_wbus  = {1'b1, 1'b1, 7'h1A, 22'h00ABC, 32'h1C00_0100};
    step();
    idle();
    for (int i = 0; i < 3; i++) step();

    // Lookups held: update forced after STARVE_MAX granted cycles
    lookup_req = 1'b1;
    upd_valid  = 1'b1;
    pht_wbus   = {1'b1, 10'h3FF, 2'b11};
    btb_wbus   = {1'b0, 1'b1, 7'h7F, 22'h3FFFF, 32'hDEAD_BEEF};
    step();
    upd_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Lookups held, back-to-back pushes fill the FIFO then drain
    for (int i = 0; i < 20; i++) begin
      rand_inputs(100, 100, 100);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) step();

    // Both we bits clear: accepted and dropped
    upd_valid = 1'b1;
    pht_wbus  = {1'b0, 10'h123, 2'b11};
    btb_wbus  = {1'b0, 1'b1, 7'h55, 22'h1, 32'h1};
    for (int i = 0; i < 3; i++) step();
    idle();

    // Mixed random traffic
    for (int i = 0; i < 1500; i++) begin
      rand_inputs((i / 300) * 25, 40 + (i % 3) * 20, 70);
      step();
    end

    // Reset with a partly full queue; bounded wait for 3 entries
    begin
      int budget = 200;
      while (model_q.size() < 3 && budget > 0) begin
        rand_inputs(100, 100, 100);
        step();
        budget--;
      end
      check("fill_for_reset", 64'(model_q.size() >= 3), 64'd1);
    end
    srst = 1'b1;
    rand_inputs(100, 100, 100);
    step();
    srst = 1'b0;
    for (int i = 0; i < INIT_CYCLES; i++) begin
      rand_inputs(50, 50, 80);
      step();
    end

    for (int i = 0; i < 300; i++) begin
      rand_inputs(60, 60, 75);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Sequences all writes into the branch predictor's single-ported PHT and BTB arrays.
- After reset, sweeps both tables to a known state.
- Buffers resolved-branch update buses (PHT wbus and BTB wbus) from the branch unit in a small FIFO.
- Arbitrates each table port cycle between fetch-stage lookups (normal priority) and queued updates; a starvation counter guarantees updates eventually win.

Parameters:
PHT_IDX_W, 10, PHT index width (PHT depth = 2^PHT_IDX_W)
BTB_IDX_W, 7, BTB index width (BTB depth = 2^BTB_IDX_W, must be <= PHT_IDX_W)
BTB_TAG_W, 22, BTB tag width
DEPTH, 4, update FIFO entries (power of 2, >= 2)
STARVE_MAX, 3, consecutive lookup-blocked cycles before an update is forced
PHT_INIT, 2'b01, PHT reset value (weak not taken)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
upd_valid_i  in  1  update bus pair valid this cycle
upd_ready_o  out  1  FIFO can accept; transfer = upd_valid_i & upd_ready_o
pht_wbus_i  in  1+PHT_IDX_W+2  {we, index, next_state}
btb_wbus_i  in  2+BTB_IDX_W+BTB_TAG_W+32  {we, wvalid, index, tag, target}
lookup_req_i  in  1  fetch requests the table port this cycle
lookup_gnt_o  out  1  fetch lookup granted this cycle
pht_we_o  out  1  PHT write strobe
pht_waddr_o  out  PHT_IDX_W  PHT write index
pht_wdata_o  out  2  PHT write state
btb_we_o  out  1  BTB write strobe
btb_waddr_o  out  BTB_IDX_W  BTB write index
btb_wvalid_o  out  1  BTB entry valid bit
btb_wtag_o  out  BTB_TAG_W  BTB tag
btb_wtarget_o  out  32  BTB target
init_done_o  out  1  sweep complete, normal operation
q_count_o  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- FSM states: INIT, RUN. Synchronous reset forces INIT and applies these reset values:
  - FIFO cleared, q_count_o=0
  - sweep index=0
  - starve counter=0
  - init_done_o=0
  - upd_ready_o=0, lookup_gnt_o=0
- Reset asserted mid-sweep or mid-drain has the same effect: queued updates are discarded and the sweep restarts from index 0.
- INIT:
  - Every cycle: pht_we_o=1, pht_waddr_o=idx, pht_wdata_o=PHT_INIT.
  - While idx < 2^BTB_IDX_W: btb_we_o=1, btb_waddr_o=idx[BTB_IDX_W-1:0], btb_wvalid_o=0; tag and target are 0.
  - Index increments each cycle. After writing index 2^PHT_IDX_W-1, move to RUN. With defaults, INIT lasts exactly 1024 cycles.
  - lookup_gnt_o=0 and upd_ready_o=0 throughout INIT.
- RUN:
  - init_done_o=1.
  - upd_ready_o = (q_count_o < DEPTH). It is computed from current occupancy only, so no push is accepted while full, even if a pop occurs in the same cycle.
- Enqueue:
  - An accepted transfer with the PHT we or the BTB we set is pushed as one entry.
  - A transfer with both we bits clear is accepted and dropped (no push).
- Write slot:
  - wslot = RUN & fifo_nonempty & (!lookup_req_i | starve==STARVE_MAX).
  - lookup_gnt_o = RUN & lookup_req_i & !wslot.
- When wslot is asserted:
  - The head entry is popped.
  - pht_we_o = head.pht_we and btb_we_o = head.btb_we; address and data fields come combinationally from the head registers.
  - Starve counter clears.
- Outside wslot in RUN, both we outputs are 0; the data fields are don't-care.
- Starve counter:
  - Increments, saturating at STARVE_MAX, in any cycle where the FIFO is non-empty and a lookup is granted.
  - Clears when the FIFO is empty.
- Latency: a transfer accepted at edge N can be written at the earliest in the cycle following edge N. There is no bypass from input to write port.
- Ordering: updates are written strictly in FIFO order. Back-to-back updates to the same index are not coalesced; the later write wins.
- Simultaneous push and pop: occupancy is unchanged, and a pop from a full FIFO frees space for the next cycle.

Test Plan:
1. Reset for 2 cycles, then idle → pht_we_o=1 for 1024 consecutive cycles with addresses 0..1023 and data 2'b01; btb_we_o=1 only for the first 128 cycles, with wvalid=0. init_done_o rises at cycle 1024; upd_ready_o=0 before that.
2. In RUN with lookup_req_i=0, push pht{1,10'h05A,2'b10} and btb{1,1,7'h1A,tag 22'h00ABC,32'h1C00_0100} → exactly one cycle later: pht_we_o=1 addr 0x05A data 2'b10, btb_we_o=1 with matching fields; q_count_o returns to 0.
3. Hold lookup_req_i=1 and push one update → lookup_gnt_o=1 for 3 cycles, then 0 for one cycle while the update writes (forced by STARVE_MAX=3), then 1 again.
4. With lookup_req_i=1 held and 5 pushes attempted back-to-back → 4 accepted, then upd_ready_o=0 and q_count_o=4. The 5th transfer is held until a forced write frees a slot. Drain order matches push order.
5. Push with both we bits 0 → upd_ready_o=1, q_count_o stays 0, no write strobe.
6. Assert reset with 3 entries queued in RUN → q_count_o=0 the next cycle, init_done_o=0, sweep restarts at address 0, and no stale entry is ever written.
